// File: rtl/food_position_gen.sv
// -----------------------------------------------------------------------------
// food_position_gen
//
// Pseudo-random food coordinate generator for the snake playfield. A
// free-running Galois LFSR, lightly perturbed by a synchronised entropy bit,
// supplies candidate values. On request a small FSM draws an in-range
// horizontal cell, then an in-range vertical cell, and presents both with a
// one-cycle valid strobe.
//
// Ports:
//   mclk        in   1     clock
//   rst         in   1     synchronous, active-high reset
//   entropy_in  in   1     asynchronous entropy bit (PS/2 data line)
//   req         in   1     request a new coordinate pair (sampled in IDLE)
//   busy        out  1     draw in progress (DRAW_H, DRAW_V, DONE)
//   valid       out  1     one-cycle strobe, pos_h/pos_v just updated
//   pos_h       out  H_W   horizontal cell, 0..H_MAX-1
//   pos_v       out  V_W   vertical cell, 0..V_MAX-1
// -----------------------------------------------------------------------------
module food_position_gen #(
    parameter int                H_MAX  = 80,
    parameter int                V_MAX  = 60,
    parameter int                H_W    = 7,
    parameter int                V_W    = 6,
    parameter int                LFSR_W = 32,
    parameter logic [LFSR_W-1:0] TAPS   = 32'h80200003,
    parameter logic [LFSR_W-1:0] SEED   = 32'h1,
    parameter int                RETRY  = 8
) (
    input  logic           mclk,
    input  logic           rst,
    input  logic           entropy_in,
    input  logic           req,
    output logic           busy,
    output logic           valid,
    output logic [H_W-1:0] pos_h,
    output logic [V_W-1:0] pos_v
);

    // A one-deep retry budget still needs a 1-bit counter to keep the
    // declaration legal; it simply never leaves zero.
    localparam int                CNT_W      = (RETRY > 1) ? $clog2(RETRY) : 1;
    localparam int                RETRY_M1   = RETRY - 1;
    localparam logic [CNT_W-1:0]  RETRY_LAST = RETRY_M1[CNT_W-1:0];

    // One extra bit so H_MAX == 2**H_W still compares correctly.
    localparam logic [H_W:0]      H_LIM      = H_MAX[H_W:0];
    localparam logic [V_W:0]      V_LIM      = V_MAX[V_W:0];

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRAW_H = 2'd1;
    localparam logic [1:0] S_DRAW_V = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic              e_meta;
    logic              e_s;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_step;
    logic [LFSR_W-1:0] lfsr_next;
    logic [1:0]        state;
    logic [CNT_W-1:0]  retry_cnt;
    logic [H_W-1:0]    h_reg;
    logic [V_W-1:0]    v_reg;
    logic [H_W-1:0]    cand_h;
    logic [V_W-1:0]    cand_v;
    logic              h_ok;
    logic              v_ok;
    logic              retry_out;

    // NOTE: every signal written here is assigned on every pass through the
    // block; a path that left one unassigned would infer a latch.
    always_comb begin
        lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
        lfsr_next = lfsr_step ^ {{(LFSR_W-1){1'b0}}, e_s};
        cand_h    = lfsr[H_W-1:0];
        cand_v    = lfsr[LFSR_W-1 -: V_W];
        h_ok      = ({1'b0, cand_h} < H_LIM);
        v_ok      = ({1'b0, cand_v} < V_LIM);
        retry_out = (retry_cnt == RETRY_LAST);
    end

    assign busy = (state != S_IDLE);

    // Two-flop synchroniser for the asynchronous PS/2 data line.
    // NOTE: sequential state is updated with non-blocking assignments so
    // every flop samples the pre-edge value of the others.
    always_ff @(posedge mclk) begin
        if (rst) begin
            e_meta <= 1'b0;
            e_s    <= 1'b0;
        end else begin
            e_meta <= entropy_in;
            e_s    <= e_meta;
        end
    end

    // Free-running LFSR. The entropy XOR can in principle hit the all-zero
    // lock-up state, so that case reloads the seed.
    always_ff @(posedge mclk) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (lfsr_next == '0) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_next;
        end
    end

    // Draw FSM: rejection sampling per axis, folding into range once the
    // retry budget is spent so the worst-case latency stays bounded.
    always_ff @(posedge mclk) begin
        if (rst) begin
            state     <= S_IDLE;
            retry_cnt <= '0;
            h_reg     <= '0;
            v_reg     <= '0;
            pos_h     <= '0;
            pos_v     <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state     <= S_DRAW_H;
                        retry_cnt <= '0;
                    end
                end
                S_DRAW_H: begin
                    if (h_ok) begin
                        h_reg     <= cand_h;
                        retry_cnt <= '0;
                        state     <= S_DRAW_V;
                    end else if (retry_out) begin
                        // Width rule guarantees cand_h - H_MAX < H_MAX.
                        h_reg     <= cand_h - H_LIM[H_W-1:0];
                        retry_cnt <= '0;
                        state     <= S_DRAW_V;
                    end else begin
                        retry_cnt <= retry_cnt + 1'b1;
                    end
                end
                S_DRAW_V: begin
                    if (v_ok) begin
                        v_reg     <= cand_v;
                        retry_cnt <= '0;
                        state     <= S_DONE;
                    end else if (retry_out) begin
                        v_reg     <= cand_v - V_LIM[V_W-1:0];
                        retry_cnt <= '0;
                        state     <= S_DONE;
                    end else begin
                        retry_cnt <= retry_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    pos_h <= h_reg;
                    pos_v <= v_reg;
                    valid <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/food_position_gen.md
# food_position_gen

Parametrised pseudo-random coordinate generator for placing food on the snake playfield. A free-running Galois LFSR, optionally perturbed by an external entropy bit (the PS/2 data line), supplies candidate values. On request, a small FSM draws a uniformly distributed, in-range horizontal and vertical cell coordinate and returns them with a one-cycle valid strobe. It sits between the PS/2 receiver and the game-logic core.

## Interface

Parameters:
- H_MAX, 80: number of horizontal cells; pos_h range is 0..H_MAX-1.
- V_MAX, 60: number of vertical cells; pos_v range is 0..V_MAX-1.
- H_W, 7: pos_h width; requires H_MAX <= 2^H_W <= 2*H_MAX.
- V_W, 6: pos_v width; requires V_MAX <= 2^V_W <= 2*V_MAX.
- LFSR_W, 32: LFSR width; requires LFSR_W >= H_W and LFSR_W >= V_W.
- TAPS, 32'h80200003: Galois feedback mask.
- SEED, 32'h1: reset and lock-up reload value; must be nonzero.
- RETRY, 8: maximum rejections per axis before folding.

Ports:
- mclk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- entropy_in, in, 1: asynchronous entropy bit (PS2D), synchronised internally.
- req, in, 1: request a new coordinate pair.
- busy, out, 1: draw in progress.
- valid, out, 1: one-cycle strobe; pos_h/pos_v are new.
- pos_h, out, H_W: horizontal cell.
- pos_v, out, V_W: vertical cell.

## Operation

- Synchroniser:
  - entropy_in passes through 2 flops; e_s is the second flop.
  - Both flops reset to 0.
- LFSR: advances every cycle, including in IDLE.
  - step = lfsr[0] ? (lfsr>>1)^TAPS : lfsr>>1.
  - next = step ^ {{LFSR_W-1{0}}, e_s}.
  - If next == 0, load SEED instead.
- Candidates are taken from the current lfsr register value:
  - cand_h = lfsr[H_W-1:0].
  - cand_v = lfsr[LFSR_W-1 -: V_W].
- FSM states: IDLE, DRAW_H, DRAW_V, DONE.
  - IDLE: on req=1, go to DRAW_H and clear the retry counter.
  - DRAW_H, cand_h < H_MAX: latch h = cand_h, clear the retry counter, go to DRAW_V.
  - DRAW_H, cand_h >= H_MAX, retry count < RETRY-1: increment the counter and stay.
  - DRAW_H, cand_h >= H_MAX, retry count = RETRY-1: latch h = cand_h - H_MAX (always in range by the width rule), go to DRAW_V.
  - DRAW_V: same three rules with cand_v, V_MAX and v; the exit goes to DONE.
  - DONE: drive pos_h <= h and pos_v <= v, assert valid for that cycle, then go to IDLE.
- req is level-sampled only in IDLE. A req held high re-triggers a new draw on the cycle after DONE.
- req during DRAW_H, DRAW_V or DONE is ignored; it is neither queued nor an error.
- pos_h/pos_v hold their value between valid strobes.
- busy = 1 in DRAW_H, DRAW_V and DONE; busy = 0 in IDLE.
- The retry counter is $clog2(RETRY) bits wide and saturates logically at RETRY-1.

## Timing

- Reset values: lfsr = SEED, state = IDLE, busy = 0, valid = 0, pos_h = 0, pos_v = 0, retry counter = 0.
- rst has priority over everything, including mid-draw: the next cycle is IDLE with no valid strobe.
- Latency with no rejections: req sampled at edge k, valid high during the cycle after edge k+3 (3 edges after acceptance).
- Maximum latency: 3 + 2*(RETRY-1) edges, which bounds worst-case food placement.
- valid is high for exactly 1 cycle per accepted req.
- pos_h/pos_v change only on the same edge that raises valid.
- Entropy affects the LFSR 2 cycles after entropy_in changes.

## Test plan

- Reset and determinism: hold entropy_in=0, assert rst for 2 cycles, pulse req once. The bench reference LFSR model (SEED=1, TAPS=32'h80200003) must predict pos_h/pos_v exactly. valid must rise exactly 3 edges after req when the model predicts no rejections. All outputs read 0 during reset.
- Range sweep: issue 10,000 back-to-back requests with random entropy_in.
  - Every pos_h < 80 and every pos_v < 60.
  - All 80 and 60 values appear.
  - Chi-square on the histogram is within the 99% bound.
- Fold path: set RETRY=1, force lfsr so that cand_h = 100 (via SEED) → pos_h = 20 with no retry cycles.
- Rejection retry: from a model-chosen state where cand_h >= 80 for 2 consecutive cycles → busy extends by 2 cycles, and pos_h equals the first in-range candidate.
- Handshake:
  - Pulse req during DRAW_H → no extra valid.
  - Hold req high for 20 cycles → valid strobes separated by exactly 4 cycles when there are no rejections.
- Lock-up and reset mid-draw:
  - Force an lfsr value whose next state is 0 → SEED is loaded.
  - Assert rst while in DRAW_V → no valid, state IDLE, pos_h/pos_v = 0.
